// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide unit with architectural HI/LO.
//
// Executes MULT/MULTU/DIV/DIVU one step per cycle (shift-add multiply,
// restoring divide), plus single-cycle MTHI/MTLO writes.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset; aborts any operation
//   start        issue request, sampled at the rising edge
//   op           0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=no-op
//   lvalue       rs operand (multiplicand / dividend / MTHI-MTLO source)
//   rvalue       rt operand (multiplier / divisor)
//   busy         multi-cycle operation in flight; start ignored while high
//   done         one-cycle pulse when HI or LO has just been written
//   div_by_zero  valid with done; last DIV/DIVU had a zero divisor
//   hi, lo       HI and LO registers
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] lvalue,
  input  logic [WIDTH-1:0] rvalue,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits / quotient bits}.
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     m_q;        // multiplicand or divisor magnitude
  logic                 is_div_q;
  logic                 neg_q;      // product / quotient must be negated
  logic                 neg_rem_q;  // remainder must be negated
  logic                 dbz_pend_q; // divisor was zero at issue
  logic                 busy_q, done_q, dbz_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  // Operand magnitudes for signed ops; the most-negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  logic                 signed_op;
  logic [WIDTH-1:0]     l_mag, r_mag;

  // One step of each datapath.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;

  // Sign-corrected results used in FIX.
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  always_comb begin
    signed_op = (op == 3'd0) || (op == 3'd2);
    l_mag     = (signed_op && lvalue[WIDTH-1]) ? -lvalue : lvalue;
    r_mag     = (signed_op && rvalue[WIDTH-1]) ? -rvalue : rvalue;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    // The borrow bit div_diff[WIDTH] is exact because the partial remainder
    // is always below the divisor before the shift.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m_q};
    div_ge    = ~div_diff[WIDTH];
    div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ge};

    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      m_q        <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                state_q    <= S_CALC;
                busy_q     <= 1'b1;
                dbz_q      <= 1'b0;
                cnt_q      <= CNT_W'(WIDTH - 1);
                is_div_q   <= op[1];
                neg_q      <= signed_op && (lvalue[WIDTH-1] ^ rvalue[WIDTH-1]);
                neg_rem_q  <= signed_op && lvalue[WIDTH-1];
                dbz_pend_q <= op[1] && (rvalue == '0);
                if (op[1]) begin
                  acc_q <= {{WIDTH{1'b0}}, l_mag};
                  m_q   <= r_mag;
                end else begin
                  acc_q <= {{WIDTH{1'b0}}, r_mag};
                  m_q   <= l_mag;
                end
              end
              3'd4: begin
                hi_q   <= lvalue;
                done_q <= 1'b1;
                dbz_q  <= 1'b0;
              end
              3'd5: begin
                lo_q   <= lvalue;
                done_q <= 1'b1;
                dbz_q  <= 1'b0;
              end
              default: ; // reserved ops leave all state untouched
            endcase
          end
        end
        S_CALC: begin
          acc_q <= is_div_q ? div_next : mul_next;
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          if (is_div_q) begin
            // A zero divisor leaves the remainder equal to the dividend
            // magnitude, so the remainder sign fix restores lvalue exactly.
            lo_q <= dbz_pend_q ? {WIDTH{1'b1}} : quo_fix;
            hi_q <= rem_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          dbz_q   <= dbz_pend_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] lvalue, rvalue;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  lvalue8, rvalue8;
  logic        busy8, done8, div_by_zero8;
  logic [7:0]  hi8, lo8;

  int n_checks = 0;
  int n_fail   = 0;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .lvalue(lvalue), .rvalue(rvalue), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  alu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8),
    .lvalue(lvalue8), .rvalue(rvalue8), .busy(busy8), .done(done8),
    .div_by_zero(div_by_zero8), .hi(hi8), .lo(lo8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] l, input logic [31:0] r);
    start  = 1'b1;
    op     = o;
    lvalue = l;
    rvalue = r;
    tick();
    start  = 1'b0;
  endtask

  // Cycles from the issue edge until done, bounded; gaps counts cycles with
  // busy low before done arrived.
  task automatic wait_done(output int n, output int gaps);
    n = 0;
    gaps = 0;
    while (n < 60) begin
      tick();
      n++;
      if (done) break;
      if (!busy) gaps++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    n_checks++; if ({busy, done, div_by_zero} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero}); end
    n_checks++; if ({hi8, lo8, busy8, done8, div_by_zero8} !== 19'd0) begin n_fail++; $display("FAIL reset_w8: got %h expected 0", {hi8, lo8, busy8, done8, div_by_zero8}); end
    $display("reset: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
  endtask

  task automatic test_mult_latency();
    int n, g;
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_start: got %b expected 1", busy); end
    wait_done(n, g);
    $display("MULT -3*5: cycles=%0d hi=%h lo=%h", n, hi, lo);
    n_checks++; if (n !== 33) begin n_fail++; $display("FAIL mult_latency: got %0d expected 33", n); end
    n_checks++; if (g !== 0) begin n_fail++; $display("FAIL mult_busy_gap: got %0d expected 0", g); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_done: got %b expected 0", busy); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffff1", lo); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_back_to_back();
    int n, g;
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n, g);
    $display("MULTU ffffffff*ffffffff: cycles=%0d hi=%h lo=%h", n, hi, lo);
    n_checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL multu_result: got %h expected fffffffe00000001", {hi, lo}); end
    // Issue in the done cycle itself.
    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b expected 1", busy); end
    n_checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL b2b_hold: got %h expected fffffffe00000001", {hi, lo}); end
    wait_done(n, g);
    $display("MULT 80000000*80000000: cycles=%0d hi=%h lo=%h", n, hi, lo);
    n_checks++; if (n !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 33", n); end
    n_checks++; if ({hi, lo} !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL b2b_result: got %h expected 4000000000000000", {hi, lo}); end
  endtask

  task automatic test_div();
    int n, g;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, g);
    $display("DIV -7/2: cycles=%0d hi=%h lo=%h", n, hi, lo);
    n_checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_signed: got %h expected fffffffffffffffd", {hi, lo}); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL div_signed_dbz: got %b expected 0", div_by_zero); end
    issue(3'd3, 32'd7, 32'd2);
    wait_done(n, g);
    $display("DIVU 7/2: cycles=%0d hi=%h lo=%h", n, hi, lo);
    n_checks++; if ({hi, lo} !== 64'h0000_0001_0000_0003) begin n_fail++; $display("FAIL divu: got %h expected 0000000100000003", {hi, lo}); end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, g);
    $display("DIV 80000000/ffffffff: cycles=%0d hi=%h lo=%h", n, hi, lo);
    n_checks++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL div_overflow: got %h expected 0000000080000000", {hi, lo}); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL div_overflow_flag: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_div_by_zero();
    int n, g;
    issue(3'd3, 32'd100, 32'd0);
    wait_done(n, g);
    $display("DIVU 100/0: cycles=%0d dbz=%b hi=%h lo=%h", n, div_by_zero, hi, lo);
    n_checks++; if (n !== 33) begin n_fail++; $display("FAIL dbz_latency: got %0d expected 33", n); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
    n_checks++; if ({hi, lo} !== 64'h0000_0064_FFFF_FFFF) begin n_fail++; $display("FAIL dbz_result: got %h expected 00000064ffffffff", {hi, lo}); end
    tick();
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_hold: got %b expected 1", div_by_zero); end
    issue(3'd1, 32'd3, 32'd4);
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_clear: got %b expected 0", div_by_zero); end
    wait_done(n, g);
    $display("MULTU 3*4: cycles=%0d hi=%h lo=%h", n, hi, lo);
    n_checks++; if ({hi, lo} !== 64'd12) begin n_fail++; $display("FAIL multu_small: got %h expected 000000000000000c", {hi, lo}); end
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1; op = 3'd4; lvalue = 32'h1234;
    tick();
    $display("MTHI 1234: hi=%h done=%b busy=%b", hi, done, busy);
    n_checks++; if ({hi, done, busy} !== {32'h1234, 1'b1, 1'b0}) begin n_fail++; $display("FAIL mthi: got hi=%h done=%b busy=%b expected hi=00001234 done=1 busy=0", hi, done, busy); end
    op = 3'd5; lvalue = 32'h5678;
    tick();
    start = 1'b0;
    $display("MTLO 5678: lo=%h done=%b busy=%b", lo, done, busy);
    n_checks++; if ({hi, lo, done, busy} !== {32'h1234, 32'h5678, 1'b1, 1'b0}) begin n_fail++; $display("FAIL mtlo: got hi=%h lo=%h done=%b busy=%b expected 00001234 00005678 1 0", hi, lo, done, busy); end
    // Reserved op: nothing happens.
    start = 1'b1; op = 3'd6; lvalue = 32'hDEAD;
    tick();
    start = 1'b0;
    n_checks++; if ({hi, lo, done, busy} !== {32'h1234, 32'h5678, 1'b0, 1'b0}) begin n_fail++; $display("FAIL reserved_op: got hi=%h lo=%h done=%b busy=%b expected 00001234 00005678 0 0", hi, lo, done, busy); end
  endtask

  task automatic test_start_while_busy();
    int n;
    int extra;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    n = 0;
    while (n < 60) begin
      if (n == 5) begin
        start = 1'b1; op = 3'd1; lvalue = 32'd2; rvalue = 32'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
      if (done) break;
    end
    start = 1'b0;
    $display("DIV -7/2 with mid start: cycles=%0d hi=%h lo=%h", n, hi, lo);
    n_checks++; if (n !== 33) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 33", n); end
    n_checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL busy_start_result: got %h expected fffffffffffffffd", {hi, lo}); end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy || done) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL busy_start_queued: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_reset_abort();
    int pulses;
    issue(3'd0, 32'd3, 32'd5);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("reset mid-MULT: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
    n_checks++; if ({hi, lo, busy, done} !== 66'd0) begin n_fail++; $display("FAIL abort_state: got hi=%h lo=%h busy=%b done=%b expected all 0", hi, lo, busy, done); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", pulses); end
  endtask

  task automatic test_width8();
    int n;
    start8 = 1'b1; op8 = 3'd0; lvalue8 = 8'hFD; rvalue8 = 8'h05;
    tick();
    start8 = 1'b0;
    n = 0;
    while (n < 30) begin
      tick();
      n++;
      if (done8) break;
    end
    $display("W8 MULT -3*5: cycles=%0d hi=%h lo=%h", n, hi8, lo8);
    n_checks++; if (n !== 9) begin n_fail++; $display("FAIL w8_latency: got %0d expected 9", n); end
    n_checks++; if ({hi8, lo8} !== 16'hFFF1) begin n_fail++; $display("FAIL w8_result: got %h expected fff1", {hi8, lo8}); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; lvalue = '0; rvalue = '0;
    start8 = 1'b0; op8 = 3'd0; lvalue8 = '0; rvalue8 = '0;
    test_reset();
    test_mult_latency();
    test_back_to_back();
    test_div();
    test_div_by_zero();
    test_mthi_mtlo();
    test_start_while_busy();
    test_reset_abort();
    test_width8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
